put_in_order: RTL

PUT_IN_ORDER -- requirements
Module: put_in_order

---
 rtl/put_in_order_slot.sv | 44 ++++
 rtl/put_in_order.sv | 100 ++++++++++
 2 files changed

// File: rtl/put_in_order_slot.sv
// put_in_order_slot
//   One holding slot of the reorder buffer: a valid flag plus a data register.
//   A write sets the flag and captures wr_data. A clear drops the flag.
//   When both happen in the same cycle the write wins. This is how a drained
//   slot is refilled by a new arrival on the same edge.
//   The data register is deliberately not reset. Only the flag qualifies it.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (clears the valid flag)
//   wr       in   capture wr_data and set the valid flag
//   clr      in   drop the valid flag (ignored when wr is also high)
//   wr_data  in   [width-1:0] data to capture
//   vld      out  slot holds a pending item
//   data     out  [width-1:0] stored item
module put_in_order_slot #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             clr,
  input  logic [width-1:0] wr_data,
  output logic             vld,
  output logic [width-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
    end else if (wr) begin
      vld <= 1'b1;
    end else if (clr) begin
      vld <= 1'b0;
    end
  end

  // Payload only; its content is meaningless while vld is low.
  always_ff @(posedge clk) begin
    if (wr) begin
      data <= wr_data;
    end
  end

endmodule

// File: rtl/put_in_order.sv
// put_in_order
//   Restores the original order of a stream that was dealt round-robin to
//   n_inputs processing units. Item k goes to unit k mod n_inputs, and units
//   may finish in any order. Each unit owns one slot. A head pointer selects
//   the unit whose result is due next. That result is emitted from the slot,
//   or bypassed directly from the unit's input when it arrives while due.
//   Emission is registered, so results appear one cycle later, at most one
//   per cycle.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   up_vld     in   [n_inputs-1:0] completion pulse, bit i = unit i
//   up_data    in   [n_inputs*width-1:0] unit i result in [i*width +: width]
//   down_vld   out  one-cycle pulse per in-order result
//   down_data  out  [width-1:0] in-order result, valid with down_vld
//   err        out  sticky flag: a unit delivered while its slot was still full
module put_in_order #(
  parameter int width    = 16,
  parameter int n_inputs = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [n_inputs-1:0]       up_vld,
  input  logic [n_inputs*width-1:0] up_data,
  output logic                      down_vld,
  output logic [width-1:0]          down_data,
  output logic                      err
);

  localparam int ptr_w = (n_inputs > 1) ? $clog2(n_inputs) : 1;
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(n_inputs - 1);

  logic [ptr_w-1:0]    rd_ptr;
  logic [n_inputs-1:0] slot_vld;
  logic [width-1:0]    slot_data [n_inputs];
  logic [width-1:0]    up_word   [n_inputs];
  logic [n_inputs-1:0] ovf;

  logic             head_ready;
  logic [width-1:0] head_data;

  genvar gi;
  generate
    for (gi = 0; gi < n_inputs; gi++) begin : g_slot
      localparam logic [ptr_w-1:0] idx = ptr_w'(gi);

      logic is_head;
      logic drain;
      logic bypass;
      logic wr;

      assign up_word[gi] = up_data[gi*width +: width];
      assign is_head     = (rd_ptr == idx);
      // The head slot empties this edge because it holds the due item.
      assign drain  = is_head & slot_vld[gi];
      // A due item with an empty head slot goes straight to the output.
      assign bypass = is_head & ~slot_vld[gi] & up_vld[gi];
      // Any arrival that is not bypassed lands in the slot. That includes
      // a new arrival on the head unit while its old item drains.
      assign wr     = up_vld[gi] & ~bypass;
      // Overwriting a pending item that is not leaving this cycle loses data.
      assign ovf[gi] = up_vld[gi] & slot_vld[gi] & ~drain;

      put_in_order_slot #(
        .width (width)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr),
        .clr     (drain),
        .wr_data (up_word[gi]),
        .vld     (slot_vld[gi]),
        .data    (slot_data[gi])
      );
    end
  endgenerate

  assign head_ready = slot_vld[rd_ptr] | up_vld[rd_ptr];
  // A stored item is always older than a fresh arrival on the same unit.
  assign head_data  = slot_vld[rd_ptr] ? slot_data[rd_ptr] : up_word[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      down_vld  <= 1'b0;
      down_data <= '0;
      err       <= 1'b0;
    end else begin
      down_vld <= head_ready;
      if (head_ready) begin
        down_data <= head_data;
        rd_ptr    <= (rd_ptr == last_ptr) ? '0 : rd_ptr + ptr_w'(1);
      end
      if (|ovf) begin
        err <= 1'b1;
      end
    end
  end

endmodule
